// File: rtl/uart_rx_frame_ctl.sv
// UART receive frame sequencer: header detect, payload write to image buffer, additive checksum, valid/ack handoff.
// Optional macro UART_RX_FRAME_DROP_CNT_EN adds a saturating drop_cnt output for dropped bytes and aborted frames.
module uart_rx_frame_ctl #(
  parameter logic [7:0] HDR_BYTE    = 8'hA5,
  parameter int         PAYLOAD_LEN = 784,
  parameter int         ADDR_W      = 10,
  parameter int         TIMEOUT_CYC = 500000,
  parameter int         TO_W        = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done_sig,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic              busy,
  output logic              err_checksum,
  output logic              err_timeout
`ifdef UART_RX_FRAME_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PAYLOAD_LEN - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CSUM, READY} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [7:0]        acc, acc_nx;
  logic [TO_W-1:0]   to_cnt, to_nx;
  logic              wr_en_nx;
  logic [ADDR_W-1:0] wr_addr_nx;
  logic [7:0]        wr_data_nx;
  logic              err_cs_nx, err_to_nx;
  logic              expire;

  // A byte arriving on the expiry cycle takes precedence over the timeout.
  assign expire = !rx_done_sig && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    acc_nx     = acc;
    to_nx      = to_cnt;
    wr_en_nx   = 1'b0;
    wr_addr_nx = wr_addr;
    wr_data_nx = wr_data;
    err_cs_nx  = 1'b0;
    err_to_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_done_sig && rx_data == HDR_BYTE) begin
          state_nx = PAYLOAD;
          cnt_nx   = '0;
          acc_nx   = '0;
          to_nx    = '0;
        end
      end
      PAYLOAD: begin
        if (rx_done_sig) begin
          wr_en_nx   = 1'b1;
          wr_addr_nx = cnt;
          wr_data_nx = rx_data;
          acc_nx     = acc + rx_data;
          cnt_nx     = cnt + ADDR_W'(1);
          to_nx      = '0;
          if (cnt == LAST_ADDR) state_nx = CSUM;
        end else if (expire) begin
          err_to_nx = 1'b1;
          state_nx  = IDLE;
        end else begin
          to_nx = to_cnt + TO_W'(1);
        end
      end
      CSUM: begin
        if (rx_done_sig) begin
          to_nx = '0;
          if (rx_data == acc) begin
            state_nx = READY;
          end else begin
            err_cs_nx = 1'b1;
            state_nx  = IDLE;
          end
        end else if (expire) begin
          err_to_nx = 1'b1;
          state_nx  = IDLE;
        end else begin
          to_nx = to_cnt + TO_W'(1);
        end
      end
      READY: begin
        if (frame_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      acc          <= '0;
      to_cnt       <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      frame_valid  <= 1'b0;
      busy         <= 1'b0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      cnt          <= cnt_nx;
      acc          <= acc_nx;
      to_cnt       <= to_nx;
      wr_en        <= wr_en_nx;
      wr_addr      <= wr_addr_nx;
      wr_data      <= wr_data_nx;
      frame_valid  <= (state_nx == READY);
      busy         <= (state_nx == PAYLOAD) || (state_nx == CSUM);
      err_checksum <= err_cs_nx;
      err_timeout  <= err_to_nx;
    end
  end

`ifdef UART_RX_FRAME_DROP_CNT_EN
  logic drop_inc, drop_clr;

  // Clear on ack wins over a byte landing in the same cycle.
  assign drop_clr = (state == READY) && frame_ack;
  assign drop_inc = ((state == READY) && !frame_ack && rx_done_sig) || err_cs_nx || err_to_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             drop_cnt <= '0;
    else if (drop_clr)                    drop_cnt <= '0;
    else if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctl.sv
// Randomized bench for uart_rx_frame_ctl with a frame-level reference model (PAYLOAD_LEN=4, TIMEOUT_CYC=100).
module tb_uart_rx_frame_ctl;

  localparam int         PLEN   = 4;
  localparam int         AW     = 4;
  localparam int         TO_CYC = 100;
  localparam logic [7:0] HDR    = 8'hA5;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_done_sig;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          frame_valid;
  logic          frame_ack;
  logic          busy;
  logic          err_checksum;
  logic          err_timeout;
`ifdef UART_RX_FRAME_DROP_CNT_EN
  logic [7:0]    drop_cnt;
  int            exp_drop = 0;
  function automatic int sat_add(input int v, input int d);
    return (v + d > 255) ? 255 : v + d;
  endfunction
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int n_ecs = 0;
  int n_eto = 0;
  logic [AW+7:0] wr_q[$];
  logic [7:0]    pl[PLEN];

  uart_rx_frame_ctl #(
    .HDR_BYTE(HDR), .PAYLOAD_LEN(PLEN), .ADDR_W(AW), .TIMEOUT_CYC(TO_CYC), .TO_W(8)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done_sig(rx_done_sig),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_valid(frame_valid), .frame_ack(frame_ack), .busy(busy),
    .err_checksum(err_checksum), .err_timeout(err_timeout)
`ifdef UART_RX_FRAME_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) wr_q.push_back({wr_addr, wr_data});
    if (err_checksum) n_ecs++;
    if (err_timeout) n_eto++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_sum();
    int s = 0;
    for (int i = 0; i < PLEN; i++) s += pl[i];
    return 8'(s % 256);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_done_sig = 1'b1;
    @(posedge clk); #1;
    rx_done_sig = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input int gap_max);
    send_byte(HDR);
    for (int i = 0; i < PLEN; i++) begin
      idle($urandom_range(gap_max, 0));
      send_byte(pl[i]);
    end
    idle($urandom_range(gap_max, 0));
    send_byte(c);
  endtask

  task automatic test_reset();
    rst = 1'b0; rx_data = '0; rx_done_sig = 1'b0; frame_ack = 1'b0;
    idle(3);
    n_cmp++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    n_cmp++; if (wr_addr !== '0) begin n_fail++; $display("FAIL reset_wr_addr: got %0h want 0", wr_addr); end
    n_cmp++; if (wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_data: got %0h want 0", wr_data); end
    n_cmp++; if ({frame_valid, busy, err_checksum, err_timeout} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {frame_valid, busy, err_checksum, err_timeout});
    end
`ifdef UART_RX_FRAME_DROP_CNT_EN
    n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
`endif
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_good_frame();
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    wr_q.delete();
    send_byte(HDR);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL good_busy: got %b want 1", busy); end
    for (int i = 0; i < PLEN; i++) send_byte(pl[i]);
    send_byte(8'h0A);
    n_cmp++; if (wr_q.size() != PLEN) begin n_fail++; $display("FAIL good_wr_count: got %0d want %0d", wr_q.size(), PLEN); end
    for (int i = 0; i < PLEN && i < wr_q.size(); i++) begin
      n_cmp++; if (wr_q[i] !== {AW'(i), pl[i]}) begin n_fail++; $display("FAIL good_wr[%0d]: got %0h want %0h", i, wr_q[i], {AW'(i), pl[i]}); end
    end
    n_cmp++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL good_valid: got %b want 1", frame_valid); end
    idle(20);
    n_cmp++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL good_valid_hold: got %b want 1", frame_valid); end
    do_ack();
    n_cmp++; if ({frame_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL good_after_ack: got %b want 00", {frame_valid, busy}); end
  endtask

  task automatic test_bad_checksum();
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    n_ecs = 0;
    send_byte(HDR);
    for (int i = 0; i < PLEN; i++) send_byte(pl[i]);
    send_byte(8'h0B);
    n_cmp++; if (err_checksum !== 1'b1) begin n_fail++; $display("FAIL bad_err_pulse: got %b want 1", err_checksum); end
    idle(2);
    n_cmp++; if (n_ecs != 1) begin n_fail++; $display("FAIL bad_err_count: got %0d want 1", n_ecs); end
    n_cmp++; if ({frame_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL bad_state: got %b want 00", {frame_valid, busy}); end
`ifdef UART_RX_FRAME_DROP_CNT_EN
    exp_drop = sat_add(exp_drop, 1);
    n_cmp++; if (drop_cnt !== 8'(exp_drop)) begin n_fail++; $display("FAIL bad_drop_cnt: got %0d want %0d", drop_cnt, exp_drop); end
`endif
    for (int i = 0; i < PLEN; i++) pl[i] = 8'($urandom);
    wr_q.delete();
    send_frame(model_sum(), 2);
    n_cmp++; if (wr_q.size() != PLEN) begin n_fail++; $display("FAIL recover_wr_count: got %0d want %0d", wr_q.size(), PLEN); end
    n_cmp++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL recover_valid: got %b want 1", frame_valid); end
    do_ack();
`ifdef UART_RX_FRAME_DROP_CNT_EN
    exp_drop = 0;
    n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL recover_drop_clr: got %0d want 0", drop_cnt); end
`endif
  endtask

  task automatic test_timeout();
    n_eto = 0;
    send_byte(HDR); send_byte(8'h01); send_byte(8'h02);
    idle(TO_CYC - 1);
    n_cmp++; if ({err_timeout, busy} !== 2'b01) begin n_fail++; $display("FAIL to_early: got %b want 01", {err_timeout, busy}); end
    idle(1);
    n_cmp++; if ({err_timeout, busy} !== 2'b10) begin n_fail++; $display("FAIL to_expire: got %b want 10", {err_timeout, busy}); end
    idle(1);
    n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL to_pulse_end: got %b want 0", err_timeout); end
    n_cmp++; if (n_eto != 1) begin n_fail++; $display("FAIL to_count: got %0d want 1", n_eto); end
    wr_q.delete();
    send_byte(8'h11); send_byte(8'h22); idle(2);
    n_cmp++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL to_late_writes: got %0d want 0", wr_q.size()); end
`ifdef UART_RX_FRAME_DROP_CNT_EN
    exp_drop = sat_add(exp_drop, 1);
    n_cmp++; if (drop_cnt !== 8'(exp_drop)) begin n_fail++; $display("FAIL to_drop_cnt: got %0d want %0d", drop_cnt, exp_drop); end
`endif
  endtask

  task automatic test_hdr_in_payload();
    pl = '{HDR, HDR, HDR, HDR};
    wr_q.delete();
    send_byte(8'h00); send_byte(8'hFF);
    n_cmp++; if ({wr_q.size() == 0, busy} !== 2'b10) begin n_fail++; $display("FAIL hdr_pre_ignored: got writes=%0d busy=%b want 0/0", wr_q.size(), busy); end
    send_byte(HDR);
    for (int i = 0; i < PLEN; i++) send_byte(pl[i]);
    send_byte(8'h94);
    n_cmp++; if (wr_q.size() != PLEN) begin n_fail++; $display("FAIL hdr_wr_count: got %0d want %0d", wr_q.size(), PLEN); end
    for (int i = 0; i < PLEN && i < wr_q.size(); i++) begin
      n_cmp++; if (wr_q[i] !== {AW'(i), HDR}) begin n_fail++; $display("FAIL hdr_wr[%0d]: got %0h want %0h", i, wr_q[i], {AW'(i), HDR}); end
    end
    n_cmp++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL hdr_valid: got %b want 1", frame_valid); end
  endtask

  task automatic test_ready_drop();
    wr_q.delete();
    send_byte(HDR); send_byte(8'h01); idle(2);
    n_cmp++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL ready_writes: got %0d want 0", wr_q.size()); end
    n_cmp++; if ({frame_valid, busy} !== 2'b10) begin n_fail++; $display("FAIL ready_state: got %b want 10", {frame_valid, busy}); end
`ifdef UART_RX_FRAME_DROP_CNT_EN
    exp_drop = sat_add(exp_drop, 2);
    n_cmp++; if (drop_cnt !== 8'(exp_drop)) begin n_fail++; $display("FAIL ready_drop_cnt: got %0d want %0d", drop_cnt, exp_drop); end
`endif
    rx_data = HDR; rx_done_sig = 1'b1;
    do_ack();
    rx_done_sig = 1'b0;
    idle(1);
    n_cmp++; if ({frame_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL ready_ack_state: got %b want 00", {frame_valid, busy}); end
`ifdef UART_RX_FRAME_DROP_CNT_EN
    exp_drop = 0;
    n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL ready_drop_clr: got %0d want 0", drop_cnt); end
`endif
  endtask

  task automatic test_random_frames();
    logic [7:0] junk, c;
    bit good;
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < PLEN; i++) pl[i] = 8'($urandom);
      junk = 8'($urandom);
      if (junk == HDR) junk = 8'h00;
      good = ($urandom_range(3, 0) != 0);
      c = good ? model_sum() : (model_sum() ^ 8'($urandom_range(255, 1)));
      wr_q.delete(); n_ecs = 0;
      send_byte(junk);
      send_frame(c, (f < 3) ? 0 : 4);
      idle(1);
      n_cmp++; if (wr_q.size() != PLEN) begin n_fail++; $display("FAIL rand%0d_wr_count: got %0d want %0d", f, wr_q.size(), PLEN); end
      for (int i = 0; i < PLEN && i < wr_q.size(); i++) begin
        n_cmp++; if (wr_q[i] !== {AW'(i), pl[i]}) begin n_fail++; $display("FAIL rand%0d_wr[%0d]: got %0h want %0h", f, i, wr_q[i], {AW'(i), pl[i]}); end
      end
      n_cmp++; if ({frame_valid, n_ecs == 1} !== {good, !good}) begin
        n_fail++; $display("FAIL rand%0d_result: got valid=%b errs=%0d want valid=%b", f, frame_valid, n_ecs, good);
      end
`ifdef UART_RX_FRAME_DROP_CNT_EN
      if (!good) exp_drop = sat_add(exp_drop, 1);
      n_cmp++; if (drop_cnt !== 8'(exp_drop)) begin n_fail++; $display("FAIL rand%0d_drop_cnt: got %0d want %0d", f, drop_cnt, exp_drop); end
`endif
      if (good) begin
        idle($urandom_range(5, 0));
        do_ack();
        n_cmp++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL rand%0d_ack: got %b want 0", f, frame_valid); end
`ifdef UART_RX_FRAME_DROP_CNT_EN
        exp_drop = 0;
`endif
      end
    end
  endtask

  task automatic test_reset_mid();
    send_byte(HDR); send_byte(8'h33); send_byte(8'h44);
    rst = 1'b0;
    #1;
    n_cmp++; if ({wr_en, frame_valid, busy, err_checksum, err_timeout} !== 5'b0) begin
      n_fail++; $display("FAIL rstmid_flags: got %b want 00000", {wr_en, frame_valid, busy, err_checksum, err_timeout});
    end
    n_cmp++; if ({wr_addr, wr_data} !== '0) begin n_fail++; $display("FAIL rstmid_data: got %0h want 0", {wr_addr, wr_data}); end
    @(posedge clk); #1;
    rst = 1'b1;
`ifdef UART_RX_FRAME_DROP_CNT_EN
    exp_drop = 0;
`endif
    for (int i = 0; i < PLEN; i++) pl[i] = 8'($urandom);
    wr_q.delete();
    send_frame(model_sum(), 1);
    n_cmp++; if (wr_q.size() != PLEN) begin n_fail++; $display("FAIL rstmid_wr_count: got %0d want %0d", wr_q.size(), PLEN); end
    for (int i = 0; i < PLEN && i < wr_q.size(); i++) begin
      n_cmp++; if (wr_q[i] !== {AW'(i), pl[i]}) begin n_fail++; $display("FAIL rstmid_wr[%0d]: got %0h want %0h", i, wr_q[i], {AW'(i), pl[i]}); end
    end
    n_cmp++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid: got %b want 1", frame_valid); end
    do_ack();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_timeout();
    test_hdr_in_payload();
    test_ready_drop();
    test_random_frames();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
